// File: rtl/btn_debouncer.sv
// btn_debouncer: per-channel synchroniser, debounce counter and auto-repeat
// generator for raw push-button pins. Every output is registered.
module btn_debouncer #(
  parameter int N               = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_repeat
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = (HMAX > 0) ? $clog2(HMAX + 1) : 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] RD_LAST   = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [HW-1:0] RP_LAST   = HW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam bit            REPEAT_EN = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rpt_state_e;

  // Hold counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
    return (v == {HW{1'b1}}) ? v : v + HW'(1);
  endfunction

  logic [N-1:0]  s1_q, s1_d;
  logic [N-1:0]  s2_q, s2_d;
  logic [N-1:0]  level_q, level_d;
  logic [N-1:0]  press_q, press_d;
  logic [N-1:0]  release_q, release_d;
  logic [N-1:0]  repeat_q, repeat_d;
  logic [DW-1:0] cnt_q [N];
  logic [DW-1:0] cnt_d [N];
  logic [HW-1:0] hcnt_q [N];
  logic [HW-1:0] hcnt_d [N];
  rpt_state_e    state_q [N];
  rpt_state_e    state_d [N];

  // Synchroniser and debounce: accept s2 only after it has disagreed with the
  // current level for DEBOUNCE_CYCLES consecutive edges; any agreement restarts.
  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        level_d[i]   = s2_q[i];
        cnt_d[i]     = '0;
        press_d[i]   = s2_q[i];
        release_d[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  // Auto-repeat: a fall always wins and is silent; a rise arms the delay,
  // after which pulses recur every REPEAT_PERIOD edges while still held.
  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      hcnt_d[i]  = hcnt_q[i];
      if (release_d[i]) begin
        state_d[i] = ST_IDLE;
        hcnt_d[i]  = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (press_d[i] && REPEAT_EN) begin
              state_d[i] = ST_DELAY;
              hcnt_d[i]  = '0;
            end
          end
          ST_DELAY: begin
            if (hcnt_q[i] == RD_LAST) begin
              state_d[i]  = ST_REPEAT;
              repeat_d[i] = 1'b1;
              hcnt_d[i]   = '0;
            end else begin
              hcnt_d[i] = sat_inc(hcnt_q[i]);
            end
          end
          ST_REPEAT: begin
            if (hcnt_q[i] == RP_LAST) begin
              repeat_d[i] = 1'b1;
              hcnt_d[i]   = '0;
            end else begin
              hcnt_d[i] = sat_inc(hcnt_q[i]);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            hcnt_d[i]  = '0;
          end
        endcase
      end
    end
  end

  // State registers; reset clears everything, including pulses in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]   <= '0;
        hcnt_q[i]  <= '0;
        state_q[i] <= ST_IDLE;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]   <= cnt_d[i];
        hcnt_q[i]  <= hcnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule
